// File: rtl/sim_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : sim_run_controller
// Purpose  : Run controller for the pipelined core: counted core reset, cycle
//            budget and PC-settle halt detection, reporting done/timeout,
//            cycle count and final PC.
// Options  : SIM_RUN_HALT_PC_EN adds a halt_pc input that ends the run on match.
// Revision : 1.0 - initial release
// ============================================================================
module sim_run_controller #(
  parameter int PC_WIDTH     = 32,
  parameter int CNT_WIDTH    = 16,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 600,
  parameter int HALT_STABLE  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PC_WIDTH-1:0]  pc,
`ifdef SIM_RUN_HALT_PC_EN
  input  logic [PC_WIDTH-1:0]  halt_pc,
`endif
  output logic                 core_rst,
  output logic                 running,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [PC_WIDTH-1:0]  final_pc
);

  localparam int c_sw = $clog2(HALT_STABLE + 1);
  localparam int c_rw = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [c_sw-1:0]      c_halt_stable = c_sw'(HALT_STABLE);
  localparam logic [CNT_WIDTH-1:0] c_max_cycles  = CNT_WIDTH'(MAX_CYCLES);
  localparam logic [c_rw-1:0]      c_rst_load    = c_rw'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESET   = 3'd1,
    S_RUN     = 3'd2,
    S_HALTED  = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t              r_state;
  logic [c_rw-1:0]     r_rst_cnt;
  logic [PC_WIDTH-1:0] r_prev_pc;
  logic                r_prev_valid;
  logic [c_sw-1:0]     r_stable_cnt;

  logic            w_pc_eq;
  logic [c_sw-1:0] w_stable_inc;
  logic            w_halt_pc;
  logic            w_halt;
  logic            w_budget;
  logic            w_launch;

  assign w_pc_eq      = r_prev_valid && (pc == r_prev_pc);
  assign w_stable_inc = r_stable_cnt + c_sw'(1);
`ifdef SIM_RUN_HALT_PC_EN
  assign w_halt_pc    = (pc == halt_pc);
`else
  assign w_halt_pc    = 1'b0;
`endif
  assign w_halt   = (w_pc_eq && (w_stable_inc == c_halt_stable)) || w_halt_pc;
  assign w_budget = (cycle_count == c_max_cycles);
  // start only launches from a resting state; RESET and RUN ignore it
  assign w_launch = start && ((r_state == S_IDLE) || (r_state == S_HALTED) ||
                              (r_state == S_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      core_rst     <= 1'b1;
      running      <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      cycle_count  <= '0;
      final_pc     <= '0;
      r_rst_cnt    <= '0;
      r_prev_pc    <= '0;
      r_prev_valid <= 1'b0;
      r_stable_cnt <= '0;
    end else if (w_launch) begin
      r_state      <= S_RESET;
      core_rst     <= 1'b1;
      running      <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      cycle_count  <= '0;
      r_rst_cnt    <= c_rst_load;
      r_prev_valid <= 1'b0;
      r_stable_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          core_rst <= 1'b1;
          running  <= 1'b0;
        end
        S_RESET: begin
          if (r_rst_cnt == '0) begin
            // cycle_count tracks the RUN cycle currently being observed
            r_state     <= S_RUN;
            core_rst    <= 1'b0;
            running     <= 1'b1;
            cycle_count <= CNT_WIDTH'(1);
          end else begin
            r_rst_cnt <= r_rst_cnt - c_rw'(1);
          end
        end
        S_RUN: begin
          r_prev_pc    <= pc;
          r_prev_valid <= 1'b1;
          r_stable_cnt <= w_pc_eq ? w_stable_inc : '0;
          if (w_halt) begin
            r_state  <= S_HALTED;
            done     <= 1'b1;
            final_pc <= pc;
            running  <= 1'b0;
          end else if (w_budget) begin
            r_state  <= S_TIMEOUT;
            done     <= 1'b1;
            timeout  <= 1'b1;
            final_pc <= pc;
            running  <= 1'b0;
          end else begin
            cycle_count <= cycle_count + CNT_WIDTH'(1);
          end
        end
        S_HALTED, S_TIMEOUT: begin
          core_rst <= 1'b0;
          running  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sim_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sim_run_controller
// Purpose  : Directed bench for sim_run_controller using three budget variants
//            (600, 10, 8 cycles) driven from shared stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sim_run_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] hp = 32'hFFFF_FFFF;

  logic        a_crst, a_run, a_done, a_to;
  logic [15:0] a_cnt;
  logic [31:0] a_fpc;
  logic        b_crst, b_run, b_done, b_to;
  logic [15:0] b_cnt;
  logic [31:0] b_fpc;
  logic        c_crst, c_run, c_done, c_to;
  logic [15:0] c_cnt;
  logic [31:0] c_fpc;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sim_run_controller #(.MAX_CYCLES(600)) u_a (
    .clk(clk), .rst(rst), .start(start), .pc(pc),
`ifdef SIM_RUN_HALT_PC_EN
    .halt_pc(hp),
`endif
    .core_rst(a_crst), .running(a_run), .done(a_done), .timeout(a_to),
    .cycle_count(a_cnt), .final_pc(a_fpc));

  sim_run_controller #(.MAX_CYCLES(10)) u_b (
    .clk(clk), .rst(rst), .start(start), .pc(pc),
`ifdef SIM_RUN_HALT_PC_EN
    .halt_pc(hp),
`endif
    .core_rst(b_crst), .running(b_run), .done(b_done), .timeout(b_to),
    .cycle_count(b_cnt), .final_pc(b_fpc));

  sim_run_controller #(.MAX_CYCLES(8)) u_c (
    .clk(clk), .rst(rst), .start(start), .pc(pc),
`ifdef SIM_RUN_HALT_PC_EN
    .halt_pc(hp),
`endif
    .core_rst(c_crst), .running(c_run), .done(c_done), .timeout(c_to),
    .cycle_count(c_cnt), .final_pc(c_fpc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // start pulse then two RESET cycles; leaves the view on RUN cycle 1
  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    tick();
    tick();
    check("rst_core_rst", a_crst, 1);
    check("rst_running", a_run, 0);
    check("rst_done", a_done, 0);
    check("rst_timeout", a_to, 0);
    check("rst_cycle_count", a_cnt, 0);
    check("rst_final_pc", a_fpc, 0);

    // launch: core_rst high for exactly two cycles after start
    rst = 1'b0;
    tick();
    check("idle_core_rst", a_crst, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("reset1_core_rst", a_crst, 1);
    check("reset1_running", a_run, 0);
    tick();
    check("reset2_core_rst", a_crst, 1);
    check("reset2_running", a_run, 0);
    tick();
    check("run1_core_rst", a_crst, 0);
    check("run1_running", a_run, 1);
    check("run1_cycle_count", a_cnt, 1);

    // halt: pc 0,4,8,12 then held at 12; halts after cycle 8
    for (int k = 1; k <= 8; k++) begin
      pc = (k <= 4) ? 32'((k - 1) * 4) : 32'd12;
      tick();
      if (k == 7) begin
        check("halt_pre_done", a_done, 0);
        check("halt_pre_cnt", a_cnt, 8);
      end
    end
    check("halt_done", a_done, 1);
    check("halt_timeout", a_to, 0);
    check("halt_running", a_run, 0);
    check("halt_cycle_count", a_cnt, 8);
    check("halt_final_pc", a_fpc, 12);
    check("halt_core_rst", a_crst, 0);
    check("tie_done", c_done, 1);
    check("tie_timeout", c_to, 0);
    check("tie_cycle_count", c_cnt, 8);
    tick();
    tick();
    check("halt_hold_cnt", a_cnt, 8);
    check("halt_hold_done", a_done, 1);

    // restart after HALTED clears done and cycle_count
    pc = 32'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_done", a_done, 0);
    check("restart_cnt", a_cnt, 0);
    check("restart_core_rst", a_crst, 1);
    tick();
    tick();
    check("restart_run_cnt", b_cnt, 1);

    // timeout: pc steps by 4; start mid-RUN must be ignored
    for (int k = 1; k <= 10; k++) begin
      pc = 32'((k - 1) * 4);
      start = (k == 3);
      tick();
      start = 1'b0;
      if (k == 8) begin
        check("to8_c_timeout", c_to, 1);
        check("to8_c_done", c_done, 1);
        check("to8_c_final_pc", c_fpc, 28);
        check("to8_c_cnt", c_cnt, 8);
      end
      if (k == 9) check("to_pre_done", b_done, 0);
    end
    check("to_done", b_done, 1);
    check("to_timeout", b_to, 1);
    check("to_cycle_count", b_cnt, 10);
    check("to_final_pc", b_fpc, 36);
    check("to_running", b_run, 0);
    check("to_a_running", a_run, 1);
    check("to_a_cnt", a_cnt, 11);

    // reset mid-run at RUN cycle 5
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pc = 32'd0;
    launch();
    for (int k = 1; k <= 4; k++) begin
      pc = 32'(k * 4);
      tick();
    end
    check("mid_running", a_run, 1);
    check("mid_cnt", a_cnt, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_core_rst", a_crst, 1);
    check("abort_running", a_run, 0);
    check("abort_done", a_done, 0);
    check("abort_cnt", a_cnt, 0);
    check("abort_final_pc", a_fpc, 0);
    tick();
    check("abort_idle_running", a_run, 0);

`ifdef SIM_RUN_HALT_PC_EN
    hp = 32'h20;
    pc = 32'd0;
    launch();
    for (int k = 1; k <= 9; k++) begin
      pc = 32'((k - 1) * 4);
      tick();
      if (k == 8) check("hpc_pre_done", a_done, 0);
    end
    check("hpc_done", a_done, 1);
    check("hpc_timeout", a_to, 0);
    check("hpc_cnt", a_cnt, 9);
    check("hpc_final_pc", a_fpc, 32'h20);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sim_run_controller.md
Name: sim_run_controller

Overview:
- Parametrised run controller for the pipelined Mips core. Replaces hand-toggled reset and fixed-length clock sequences with counted reset, a cycle budget and halt detection.
- Sits between the top-level clock/reset and the core's reset input.
- Counts executed cycles and detects program end by watching the core PC settle.
- Reports done, timeout, cycle count and final PC to the bench or to a debug register.

Parameters:
- PC_WIDTH, 32, width of the monitored PC.
- CNT_WIDTH, 16, width of the cycle counter.
- RESET_CYCLES, 2, cycles core_rst is held high after start (minimum 1).
- MAX_CYCLES, 600, cycle budget in RUN before timeout (minimum 1, must be < 2^CNT_WIDTH).
- HALT_STABLE, 4, number of consecutive equal PC comparisons that declare halt (minimum 1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- start  input  1  single-cycle pulse that launches a run.
- pc  input  PC_WIDTH  current core PC.
- core_rst  output  1  reset driven to the core.
- running  output  1  high while in RUN.
- done  output  1  sticky; run finished, by halt or by timeout.
- timeout  output  1  sticky; run ended on budget exhaustion.
- cycle_count  output  CNT_WIDTH  number of RUN cycles elapsed.
- final_pc  output  PC_WIDTH  PC captured at halt or timeout.

Behaviour:
- All outputs are registered.
- State machine states: IDLE, RESET, RUN, HALTED, TIMEOUT.
- rst high at a rising edge: state=IDLE, core_rst=1, running=0, done=0, timeout=0, cycle_count=0, final_pc=0, stable_cnt=0, prev_valid=0. rst has priority over all other inputs. rst mid-run aborts the run immediately.
- IDLE: core_rst=1. start=1 -> RESET. The reset counter loads RESET_CYCLES-1.
- RESET:
  - core_rst=1; done, timeout and cycle_count are cleared on entry.
  - The counter decrements each cycle. When it reaches 0 -> RUN, so core_rst is high for exactly RESET_CYCLES cycles.
- RUN:
  - core_rst=0, running=1. cycle_count increments by 1 every RUN cycle; the first RUN cycle shows 1.
  - prev_pc <= pc each cycle. On the first RUN cycle prev_valid=0, so no comparison is made; it is set afterwards.
  - When prev_valid=1: pc==prev_pc -> stable_cnt+1; otherwise stable_cnt=0.
  - Halt: the comparison that brings stable_cnt to HALT_STABLE -> HALTED. done=1, final_pc=pc, running=0.
  - Timeout: a RUN cycle in which cycle_count becomes MAX_CYCLES and no halt occurs -> TIMEOUT. done=1, timeout=1, final_pc=pc.
  - Halt and budget exhaustion in the same cycle: halt wins, timeout=0.
  - start in RUN or RESET is ignored.
- HALTED / TIMEOUT:
  - core_rst=0, running=0; cycle_count, final_pc, done and timeout hold.
  - start=1 -> RESET, beginning a fresh run.
- cycle_count never wraps: it stops incrementing outside RUN, and the budget ends RUN first.
- stable_cnt width is clog2(HALT_STABLE+1). stable_cnt and prev_valid clear on entry to RESET.

Optional Feature:
- Macro: SIM_RUN_HALT_PC_EN.
- Defined:
  - Adds input port halt_pc [PC_WIDTH].
  - In RUN, pc==halt_pc also triggers HALTED in the same cycle, independent of stable_cnt. This halt still has priority over timeout.
- Undefined: the port is absent, and only PC-stability halt and timeout end a run.

Test Plan:
- Reset and launch: rst for 2 cycles, then a start pulse with RESET_CYCLES=2 -> core_rst high for exactly 2 cycles after start. running rises on the next cycle; cycle_count=1 on the first RUN cycle.
- Halt detection, HALT_STABLE=4: PC sequence 0,4,8,12, then held at 12 -> HALTED after the 4th equal comparison. cycle_count=8, done=1, timeout=0, final_pc=12.
- Timeout, MAX_CYCLES=10: PC increments by 4 every cycle -> TIMEOUT when cycle_count=10. done=1, timeout=1, final_pc=36.
- Tie, MAX_CYCLES=8, HALT_STABLE=4: PC 0,4,8,12 then held at 12 (halt completes exactly at cycle_count=8) -> HALTED, timeout=0.
- Reset mid-run and restart:
  - rst asserted at cycle 5 of RUN -> next edge: IDLE, core_rst=1, all outputs at reset values.
  - After HALTED, a start pulse -> RESET, done and cycle_count cleared.
- With SIM_RUN_HALT_PC_EN, halt_pc=0x20 and PC stepping by 4 from 0 -> HALTED when pc=0x20, with cycle_count=9 and final_pc=0x20.
